bubblesort_control: RTL and testbench

- Moore-style control unit (FSM) for the bubble-sort datapath.
- Sequences the outer and inner loop counters, memory reads and writes, compare and swap operations.
- Drives mux selects, register load strobes and end-of-conversion set/clear.
- Sits beside the ALU, RAM, REG16 and MUX blocks in the sorter top level; its only datapath feedback is the ALU less-than flag.

---
 rtl/bubblesort_pkg.sv | 32 +++
 rtl/bubblesort_ctrl_decode.sv | 104 ++++++++++
 rtl/bubblesort_control.sv | 80 ++++++++
 tb/tb_bubblesort_control.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bubblesort_pkg.sv
// rtl/bubblesort_pkg.sv - shared state encoding and select/op constants for the bubble-sort control unit
package bubblesort_pkg;

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    INIT_I  = 4'd1,
    TEST_I  = 4'd2,
    INIT_J  = 4'd3,
    TEST_J  = 4'd4,
    READ_A  = 4'd5,
    READ_B  = 4'd6,
    COMPARE = 4'd7,
    WRITE_I = 4'd8,
    WRITE_J = 4'd9,
    INC_J   = 4'd10,
    INC_I   = 4'd11,
    DONE    = 4'd12
  } state_e;

  // op1 / address selects share the i=0, j=1 positions; op2 selects are a separate space
  localparam logic [1:0] SEL_I    = 2'd0;
  localparam logic [1:0] SEL_J    = 2'd1;
  localparam logic [1:0] SEL_A    = 2'd2;
  localparam logic [1:0] SEL_N    = 2'd0;
  localparam logic [1:0] SEL_B    = 2'd1;
  localparam logic [1:0] SEL_ONE  = 2'd2;
  localparam logic [1:0] SEL_ZERO = 2'd3;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/bubblesort_ctrl_decode.sv
// rtl/bubblesort_ctrl_decode.sv - combinational state-to-output decoder (Moore outputs)
module bubblesort_ctrl_decode
  import bubblesort_pkg::*;
(
  input  logic [3:0] state_i,
  output logic       rd_o,
  output logic       wr_o,
  output logic       operation_o,
  output logic       clr_o,
  output logic       preset_o,
  output logic       m3_sel_o,
  output logic       m5_sel_o,
  output logic       m6_sel_o,
  output logic [1:0] m1_sel_o,
  output logic [1:0] m4_sel_o,
  output logic [1:0] m2_sel_o,
  output logic       ln_o,
  output logic       li_o,
  output logic       lj_o,
  output logic       lk_o,
  output logic       la_o,
  output logic       lb_o
);

  always_comb begin
    rd_o        = 1'b0;
    wr_o        = 1'b0;
    operation_o = OP_ADD;
    clr_o       = 1'b0;
    preset_o    = 1'b0;
    m3_sel_o    = 1'b0;
    m5_sel_o    = 1'b0;
    m6_sel_o    = 1'b0;
    m1_sel_o    = 2'd0;
    m4_sel_o    = 2'd0;
    m2_sel_o    = 2'd0;
    ln_o        = 1'b0;
    li_o        = 1'b0;
    lj_o        = 1'b0;
    lk_o        = 1'b0;
    la_o        = 1'b0;
    lb_o        = 1'b0;
    case (state_i)
      IDLE:   clr_o = 1'b1;
      INIT_I: begin
        li_o = 1'b1;
        ln_o = 1'b1;
      end
      TEST_I: begin
        m1_sel_o = SEL_I;
        m2_sel_o = SEL_N;
      end
      INIT_J: begin
        m1_sel_o = SEL_I;
        m2_sel_o = SEL_ONE;
        m6_sel_o = 1'b1;
        lj_o     = 1'b1;
      end
      TEST_J: begin
        m1_sel_o = SEL_J;
        m2_sel_o = SEL_N;
      end
      READ_A: begin
        m4_sel_o = SEL_I;
        rd_o     = 1'b1;
        la_o     = 1'b1;
      end
      READ_B: begin
        m4_sel_o = SEL_J;
        rd_o     = 1'b1;
        lb_o     = 1'b1;
      end
      COMPARE: begin
        m1_sel_o = SEL_A;
        m2_sel_o = SEL_B;
      end
      // swap: b goes to M[i], a goes to M[j]
      WRITE_I: begin
        m4_sel_o = SEL_I;
        m3_sel_o = 1'b1;
        wr_o     = 1'b1;
      end
      WRITE_J: begin
        m4_sel_o = SEL_J;
        wr_o     = 1'b1;
      end
      INC_J: begin
        m1_sel_o = SEL_J;
        m2_sel_o = SEL_ONE;
        m6_sel_o = 1'b1;
        lj_o     = 1'b1;
      end
      INC_I: begin
        m1_sel_o = SEL_I;
        m2_sel_o = SEL_ONE;
        m5_sel_o = 1'b1;
        li_o     = 1'b1;
      end
      DONE:    preset_o = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/bubblesort_control.sv
// rtl/bubblesort_control.sv - bubble-sort control FSM: state register, next-state logic, output decoder
module bubblesort_control
  import bubblesort_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       lt,
  output logic       rd,
  output logic       wr,
  output logic       operation,
  output logic       clr,
  output logic       preset,
  output logic       m3_sel,
  output logic       m5_sel,
  output logic       m6_sel,
  output logic [1:0] m1_sel,
  output logic [1:0] m4_sel,
  output logic [1:0] m2_sel,
  output logic       ln,
  output logic       li,
  output logic       lj,
  output logic       lk,
  output logic       la,
  output logic       lb,
  output logic [3:0] state_out
);

  state_e state_q, state_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = start ? INIT_I : IDLE;
      INIT_I:  state_d = TEST_I;
      TEST_I:  state_d = lt ? INIT_J : DONE;
      INIT_J:  state_d = TEST_J;
      TEST_J:  state_d = lt ? READ_A : INC_I;
      READ_A:  state_d = READ_B;
      READ_B:  state_d = COMPARE;
      // equal values take the swap path; exchanging them changes nothing
      COMPARE: state_d = lt ? INC_J : WRITE_I;
      WRITE_I: state_d = WRITE_J;
      WRITE_J: state_d = INC_J;
      INC_J:   state_d = TEST_J;
      INC_I:   state_d = TEST_I;
      DONE:    state_d = start ? DONE : IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign state_out = state_q;

  bubblesort_ctrl_decode u_decode (
    .state_i     (state_q),
    .rd_o        (rd),
    .wr_o        (wr),
    .operation_o (operation),
    .clr_o       (clr),
    .preset_o    (preset),
    .m3_sel_o    (m3_sel),
    .m5_sel_o    (m5_sel),
    .m6_sel_o    (m6_sel),
    .m1_sel_o    (m1_sel),
    .m4_sel_o    (m4_sel),
    .m2_sel_o    (m2_sel),
    .ln_o        (ln),
    .li_o        (li),
    .lj_o        (lj),
    .lk_o        (lk),
    .la_o        (la),
    .lb_o        (lb)
  );

endmodule

// File: tb/tb_bubblesort_control.sv
// tb/tb_bubblesort_control.sv - self-checking bench: state walks against the state table plus a sort over a datapath model
module tb_bubblesort_control;

  logic       clk = 1'b0;
  logic       rst, start, lt, lt_man, integ, load;
  logic       rd, wr, operation, clr, preset, m3_sel, m5_sel, m6_sel;
  logic [1:0] m1_sel, m4_sel, m2_sel;
  logic       ln, li, lj, lk, la, lb;
  logic [3:0] state_out;

  int errors = 0;
  int checks = 0;

  logic [3:0] exp_st_q [$];
  logic [7:0] exp_mem_q [$];

  always #5 clk = ~clk;

  bubblesort_control dut (
    .clk(clk), .rst(rst), .start(start), .lt(lt),
    .rd(rd), .wr(wr), .operation(operation), .clr(clr), .preset(preset),
    .m3_sel(m3_sel), .m5_sel(m5_sel), .m6_sel(m6_sel),
    .m1_sel(m1_sel), .m4_sel(m4_sel), .m2_sel(m2_sel),
    .ln(ln), .li(li), .lj(lj), .lk(lk), .la(la), .lb(lb),
    .state_out(state_out)
  );

  wire [19:0] outs = {rd, wr, operation, clr, preset, m3_sel, m5_sel, m6_sel,
                      m1_sel, m4_sel, m2_sel, ln, li, lj, lk, la, lb};

  // reference output table, one row per state
  function automatic logic [19:0] exp_outs(input logic [3:0] s);
    logic e_rd, e_wr, e_op, e_clr, e_pre, e_m3, e_m5, e_m6, e_ln, e_li, e_lj, e_la, e_lb;
    logic [1:0] e_m1, e_m4, e_m2;
    {e_rd, e_wr, e_op, e_clr, e_pre, e_m3, e_m5, e_m6, e_ln, e_li, e_lj, e_la, e_lb} = '0;
    {e_m1, e_m4, e_m2} = '0;
    case (s)
      4'd0:  e_clr = 1'b1;
      4'd1:  begin e_li = 1'b1; e_ln = 1'b1; end
      4'd3:  begin e_m2 = 2'd2; e_m6 = 1'b1; e_lj = 1'b1; end
      4'd4:  e_m1 = 2'd1;
      4'd5:  begin e_rd = 1'b1; e_la = 1'b1; end
      4'd6:  begin e_m4 = 2'd1; e_rd = 1'b1; e_lb = 1'b1; end
      4'd7:  begin e_m1 = 2'd2; e_m2 = 2'd1; end
      4'd8:  begin e_m3 = 1'b1; e_wr = 1'b1; end
      4'd9:  begin e_m4 = 2'd1; e_wr = 1'b1; end
      4'd10: begin e_m1 = 2'd1; e_m2 = 2'd2; e_m6 = 1'b1; e_lj = 1'b1; end
      4'd11: begin e_m2 = 2'd2; e_m5 = 1'b1; e_li = 1'b1; end
      4'd12: e_pre = 1'b1;
      default: ;
    endcase
    return {e_rd, e_wr, e_op, e_clr, e_pre, e_m3, e_m5, e_m6,
            e_m1, e_m4, e_m2, e_ln, e_li, e_lj, 1'b0, e_la, e_lb};
  endfunction

  // datapath model: ALU, muxes, RAM and registers around the controller
  logic [7:0] mem [8];
  logic [7:0] init_vals [8];
  logic [7:0] n_in, n_q, i_q, j_q, a_q, b_q, op1, op2, alu_y;
  logic [2:0] addr;
  int wr_count, rd_count;

  always_comb begin
    case (m1_sel)
      2'd0: op1 = i_q;
      2'd1: op1 = j_q;
      2'd2: op1 = a_q;
      default: op1 = 8'd0;
    endcase
    case (m2_sel)
      2'd0: op2 = n_q;
      2'd1: op2 = b_q;
      2'd2: op2 = 8'd1;
      default: op2 = 8'd0;
    endcase
    alu_y = operation ? (op1 - op2) : (op1 + op2);
    case (m4_sel)
      2'd0: addr = i_q[2:0];
      2'd1: addr = j_q[2:0];
      default: addr = 3'd0;
    endcase
  end

  assign lt = integ ? (op1 < op2) : lt_man;

  always @(posedge clk) begin
    if (load) begin
      for (int k = 0; k < 8; k++) mem[k] <= init_vals[k];
      wr_count <= 0;
      rd_count <= 0;
    end else if (integ) begin
      if (ln) n_q <= n_in;
      if (li) i_q <= m5_sel ? alu_y : 8'd0;
      if (lj) j_q <= m6_sel ? alu_y : 8'd0;
      if (la) a_q <= mem[addr];
      if (lb) b_q <= mem[addr];
      if (wr) mem[addr] <= m3_sel ? b_q : a_q;
      if (wr) wr_count <= wr_count + 1;
      if (rd) rd_count <= rd_count + 1;
    end
  end

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; lt_man = 1'b0; integ = 1'b0; load = 1'b0; n_in = 8'd0;
    #12;
    checks++;
    if (state_out !== 4'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", state_out); end
    checks++;
    if ({rd, wr} !== 2'b00) begin errors++; $display("FAIL reset_rdwr got=%b exp=00", {rd, wr}); end
    @(negedge clk); rst = 1'b0;
    for (int s = 0; s < 3; s++) begin
      exp_st_q.push_back(4'd0);
      @(posedge clk); #1;
      begin
        logic [3:0] e = exp_st_q.pop_front();
        checks++;
        if (state_out !== e) begin errors++; $display("FAIL idle_hold step%0d got=%0d exp=%0d", s, state_out, e); end
        checks++;
        if (outs !== exp_outs(e)) begin errors++; $display("FAIL idle_outs step%0d got=%h exp=%h", s, outs, exp_outs(e)); end
      end
    end
  endtask

  task automatic test_outer_entry();
    logic       st_in [4] = '{1'b1, 1'b1, 1'b1, 1'b1};
    logic       lt_in [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [3:0] nx    [4] = '{4'd1, 4'd2, 4'd3, 4'd4};
    for (int s = 0; s < 4; s++) begin
      start = st_in[s]; lt_man = lt_in[s]; exp_st_q.push_back(nx[s]);
      @(posedge clk); #1;
      begin
        logic [3:0] e = exp_st_q.pop_front();
        checks++;
        if (state_out !== e) begin errors++; $display("FAIL outer_entry step%0d got=%0d exp=%0d", s, state_out, e); end
        checks++;
        if (outs !== exp_outs(e)) begin errors++; $display("FAIL outer_entry_outs step%0d got=%h exp=%h", s, outs, exp_outs(e)); end
      end
    end
  endtask

  task automatic test_inner_loop();
    logic       lt_in [12] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0,
                               1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [3:0] nx    [12] = '{4'd5, 4'd6, 4'd7, 4'd10, 4'd4,
                               4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd4};
    for (int s = 0; s < 12; s++) begin
      start = 1'b1; lt_man = lt_in[s]; exp_st_q.push_back(nx[s]);
      @(posedge clk); #1;
      begin
        logic [3:0] e = exp_st_q.pop_front();
        checks++;
        if (state_out !== e) begin errors++; $display("FAIL inner_loop step%0d got=%0d exp=%0d", s, state_out, e); end
        checks++;
        if (outs !== exp_outs(e)) begin errors++; $display("FAIL inner_loop_outs step%0d got=%h exp=%h", s, outs, exp_outs(e)); end
      end
    end
  endtask

  task automatic test_loop_exit();
    logic       st_in [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic       lt_in [7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [3:0] nx    [7] = '{4'd11, 4'd2, 4'd12, 4'd12, 4'd12, 4'd0, 4'd0};
    for (int s = 0; s < 7; s++) begin
      start = st_in[s]; lt_man = lt_in[s]; exp_st_q.push_back(nx[s]);
      @(posedge clk); #1;
      begin
        logic [3:0] e = exp_st_q.pop_front();
        checks++;
        if (state_out !== e) begin errors++; $display("FAIL loop_exit step%0d got=%0d exp=%0d", s, state_out, e); end
        checks++;
        if (outs !== exp_outs(e)) begin errors++; $display("FAIL loop_exit_outs step%0d got=%h exp=%h", s, outs, exp_outs(e)); end
      end
    end
  endtask

  task automatic test_async_reset();
    logic       lt_in [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [3:0] nx    [7] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7};
    for (int s = 0; s < 7; s++) begin
      start = 1'b1; lt_man = lt_in[s]; exp_st_q.push_back(nx[s]);
      @(posedge clk); #1;
      begin
        logic [3:0] e = exp_st_q.pop_front();
        checks++;
        if (state_out !== e) begin errors++; $display("FAIL reset_walk step%0d got=%0d exp=%0d", s, state_out, e); end
      end
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (state_out !== 4'd0) begin errors++; $display("FAIL async_reset_state got=%0d exp=0", state_out); end
    checks++;
    if ({rd, wr} !== 2'b00) begin errors++; $display("FAIL async_reset_rdwr got=%b exp=00", {rd, wr}); end
    start = 1'b0;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic run_sort(input int n, input string tag, input logic no_writes);
    logic [7:0] srt [8];
    int cyc;
    for (int k = 0; k < 8; k++) srt[k] = init_vals[k];
    for (int x = 1; x < n; x++)
      for (int y = x; y > 0 && srt[y-1] > srt[y]; y--) begin
        logic [7:0] t = srt[y]; srt[y] = srt[y-1]; srt[y-1] = t;
      end
    for (int k = 0; k < 8; k++) exp_mem_q.push_back(srt[k]);
    @(negedge clk); load = 1'b1; integ = 1'b0; start = 1'b0;
    @(negedge clk); load = 1'b0; n_in = n[7:0]; integ = 1'b1; start = 1'b1;
    cyc = 0;
    do begin @(posedge clk); #1; cyc++; end while (state_out !== 4'd12 && cyc < 2000);
    checks++;
    if (state_out !== 4'd12) begin errors++; $display("FAIL %s_done got=%0d exp=12 after %0d cycles", tag, state_out, cyc); end
    if (n == 0) begin
      checks++;
      if (cyc !== 3) begin errors++; $display("FAIL %s_latency got=%0d exp=3", tag, cyc); end
    end
    if (n <= 1) begin
      checks++;
      if (rd_count !== 0) begin errors++; $display("FAIL %s_reads got=%0d exp=0", tag, rd_count); end
    end
    if (no_writes) begin
      checks++;
      if (wr_count !== 0) begin errors++; $display("FAIL %s_writes got=%0d exp=0", tag, wr_count); end
    end
    for (int k = 0; k < 8; k++) begin
      logic [7:0] e = exp_mem_q.pop_front();
      checks++;
      if (mem[k] !== e) begin errors++; $display("FAIL %s_mem[%0d] got=%0d exp=%0d", tag, k, mem[k], e); end
    end
    start = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (state_out !== 4'd0 || clr !== 1'b1) begin
      errors++; $display("FAIL %s_return got=%0d clr=%b exp=0 clr=1", tag, state_out, clr);
    end
    integ = 1'b0;
  endtask

  initial begin
    test_reset();
    test_outer_entry();
    test_inner_loop();
    test_loop_exit();
    test_async_reset();

    for (int k = 0; k < 8; k++) init_vals[k] = (k < 7) ? 8'(7 - k) : 8'd99;
    run_sort(7, "reversed", 1'b0);
    for (int k = 0; k < 8; k++) init_vals[k] = (k < 7) ? 8'(k + 1) : 8'd99;
    run_sort(7, "sorted", 1'b1);
    for (int k = 0; k < 8; k++) init_vals[k] = 8'($urandom_range(0, 15));
    run_sort(6, "random", 1'b0);
    for (int k = 0; k < 8; k++) init_vals[k] = 8'(50 - k);
    run_sort(1, "n1", 1'b1);
    run_sort(0, "n0", 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
